// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// ------------------
// Multicycle control FSM for an RV32I core. It decodes the opcode/funct3
// held in the instruction register. From the current state it drives the
// datapath mux selects, the ALU-decoder op class and the write enables.
// All outputs are Moore outputs of the current state. The exceptions are
// ir_write and pc_update: these also depend on the current-cycle memory
// ready (FETCH) or branch flags (BRANCH). No output is registered.
//
// Memory handshake: mem_req is held high for the whole of an access state
// (FETCH, MEMREAD, MEMWRITE). The access completes in the cycle where
// mem_req and mem_ready are both high, and the FSM then leaves the state.
// While mem_ready is low, every output stays stable, including adr_src and
// mem_write. When MEM_WAIT=0, mem_ready is ignored and every access
// completes in one cycle.
//
// Ports
//   clk, reset          clock, synchronous active-high reset (-> FETCH)
//   opcode, funct3      instruction fields from IR
//   zero/lt/ltu_flag    ALU comparison flags for branches
//   mem_ready           memory completes the current access this cycle
//   mem_req, adr_src    memory request, address select (0 PC, 1 ALUOut)
//   ir_write, mem_write IR/OldPC load, store strobe
//   reg_write           register file write
//   pc_update, branch   PC write enable, in-branch indicator
//   alu_src_a/b, alu_op ALU operand selects and op class
//   result_src          writeback select
//   illegal             trap indicator
//   fsm_state           current state encoding (debug/checker visibility)
module rv_multicycle_ctrl #(
  parameter bit MEM_WAIT        = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit BRANCH_FULL     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero_flag,
  input  logic       lt_flag,
  input  logic       ltu_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_update,
  output logic       branch,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic [3:0] fsm_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_JAL      = 4'd4,
    S_JALR     = 4'd5,
    S_JALR_PC  = 4'd6,
    S_LUI      = 4'd7,
    S_MEMADR   = 4'd8,
    S_MEMREAD  = 4'd9,
    S_MEMWB    = 4'd10,
    S_MEMWRITE = 4'd11,
    S_BRANCH   = 4'd12,
    S_ALUWB    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state;
  state_t state_next;
  logic   rdy;
  logic   taken;
  logic   branch_legal;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  assign rdy       = MEM_WAIT ? mem_ready : 1'b1;
  assign fsm_state = state;

  // funct3 010/011 are not branches. The reduced variant supports BEQ only.
  assign branch_legal = (funct3 != 3'b010) && (funct3 != 3'b011) &&
                        (BRANCH_FULL || (funct3 == 3'b000));

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero_flag;
      3'b001:  taken = !zero_flag;
      3'b100:  taken = lt_flag;
      3'b101:  taken = !lt_flag;
      3'b110:  taken = ltu_flag;
      3'b111:  taken = !ltu_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    result_src = 2'b00;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed alongside the fetch, so the PC advances together
        // with the IR load.
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = rdy;
        pc_update  = rdy;
        if (rdy) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC+imm, which is the branch/JAL target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_R:                state_next = S_EXEC_R;
          OP_I:                state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:   state_next = S_MEMADR;
          OP_JAL:              state_next = S_JAL;
          OP_JALR:             state_next = S_JALR;
          OP_LUI:              state_next = S_LUI;
          OP_AUIPC:            state_next = S_ALUWB;
          OP_BRANCH: begin
            if (branch_legal)         state_next = S_BRANCH;
            else if (TRAP_ON_ILLEGAL) state_next = S_TRAP;
            else                      state_next = S_FETCH;
          end
          default: begin
            if (TRAP_ON_ILLEGAL) state_next = S_TRAP;
            else                 state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_op     = 3'b010;
        state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 3'b011;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        // The PC takes the target held in ALUOut. OldPC+4 is computed for rd.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = S_JALR_PC;
      end
      S_JALR_PC: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (rdy) state_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (rdy) state_next = S_FETCH;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 3'b001;
        branch     = 1'b1;
        pc_update  = taken;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule
